serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder. A single one-bit full adder is sequenced over WIDTH clock cycles, LSB first, under a start/busy/done handshake. The block holds the carry in a flip-flop between bits and assembles the result in a shift register. It gives the lab datapath a cheap area/latency trade-off against a ripple-carry adder.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  single clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in S_IDLE.
a  input  WIDTH  operand A; captured on the accepting edge.
b  input  WIDTH  operand B; captured on the accepting edge.
cin  input  1  carry-in; captured on the accepting edge.
busy  output  1  high in S_RUN and S_DONE.
done  output  1  high for exactly one cycle, in S_DONE.
sum  output  WIDTH  result; valid while done=1, held afterwards.
cout  output  1  carry out of MSB; valid while done=1, held afterwards.
ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: state=S_IDLE; busy=0, done=0, sum=0, cout=0, ovf=0. All internal registers (a_sh, b_sh, carry, cnt) clear to 0.
- Reset mid-operation: aborts immediately. Outputs go to their reset values. No done pulse is produced. The next start after reset release is accepted normally.
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- FSM states: S_IDLE, S_RUN, S_DONE.
- S_IDLE, start=1 at edge E0:
  - a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum<=0, state<=S_RUN.
  - start=0: stay in S_IDLE; sum, cout and ovf hold their values.
- S_RUN, each edge:
  - Full-adder inputs are a_sh[0], b_sh[0] and carry.
  - sum <= {fa_sum, sum[WIDTH-1:1]} (shift right, new bit enters at MSB).
  - carry<=fa_cout; a_sh and b_sh shift right with zero fill; cnt<=cnt+1.
  - When cnt==WIDTH-1 (MSB bit): cout<=fa_cout, ovf<=carry^fa_cout, state<=S_DONE.
- S_DONE: done=1 for this cycle only; next edge returns to S_IDLE unconditionally.
- Latency: start accepted at edge E0; S_DONE is entered at edge E0+WIDTH; done is high for the cycle between edges E0+WIDTH and E0+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while busy=1 (including in S_DONE): ignored, not queued. A start still high in S_IDLE after completion starts a new operation.
- a, b and cin may change freely after the accepting edge; the result depends only on the captured values.
- sum, cout and ovf hold the last result until the next accepted start, or until reset. During S_RUN, sum shows partial shift contents and must not be checked.
- Counter: width $clog2(WIDTH); no wrap-around, because the exit happens at WIDTH-1.
- Arithmetic: {cout,sum} == a + b + cin, unsigned, WIDTH+1 bits.

Decomposition:
- Shared package serial_adder_pkg:
  - typedef enum logic [1:0] state_e {S_IDLE, S_RUN, S_DONE}.
  - localparam CNT_W function of WIDTH.
- Sub-module: one instance of the existing one-bit full adder fa (input1, input2, carry_in, sum, carry_out) as the datapath.
- The FSM, carry flip-flop and shift registers live in serial_adder_ctrl itself.

Test Plan:
1. Reset: assert rst for 3 cycles with start=1 -> busy=0, done=0, sum=0, cout=0, ovf=0. No start accepted while rst=1.
2. WIDTH=8, a=8'h3C, b=8'h05, cin=0, start pulse -> done high exactly 8 cycles after the accepting edge, one cycle wide. sum=8'h41, cout=0, ovf=0, held 5 idle cycles later.
3. Boundary values:
   - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0.
   - a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
   - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1, ovf=0.
4. Busy handling: start held high continuously with operands changed mid-RUN -> the first result uses the captured operands. The next accept happens on the first S_IDLE edge; busy is low for exactly 1 cycle between the two operations.
5. Reset mid-operation: rst pulses during cycle 3 of S_RUN -> outputs immediately zero, no done pulse. A fresh start with a=8'h10, b=8'h20 -> sum=8'h30.
6. Exhaustive check at WIDTH=3: all 128 combinations of a, b and cin -> {cout,sum}==a+b+cin and ovf matches the signed overflow for every case.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bit-counter width for a given operand width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fa.sv
// One-bit full adder used as the serial datapath.
module fa (
    input  logic input1,
    input  logic input2,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = input1 ^ input2 ^ carry_in;
    assign carry_out = (input1 & input2) | (carry_in & (input1 ^ input2));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder sequenced LSB first under a
// start/busy/done handshake, result assembled in a right-shifting register.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned          CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_sum, fa_cout;

    fa u_fa (
        .input1    (a_sh_q[0]),
        .input2    (b_sh_q[0]),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                carry_d = fa_cout;
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // carry_q here is the carry into the MSB
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and an exhaustive WIDTH=3 instance.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       cin3 = 1'b0;
    logic       busy3, done3, cout3, ovf3;
    logic [2:0] sum3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder_ctrl #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3)
    );

    // Reference: bits [w:0] = unsigned a+b+cin, bit w+1 = signed overflow.
    function automatic int model(input int w, input int av, input int bv, input int cv);
        int u, sa, sb, s, half;
        half = 1 << (w - 1);
        u    = av + bv + cv;
        sa   = (av >= half) ? av - 2 * half : av;
        sb   = (bv >= half) ? bv - 2 * half : bv;
        s    = sa + sb + cv;
        return (((s > half - 1) || (s < -half)) ? (1 << (w + 1)) : 0) | u;
    endfunction

    // Runs one WIDTH=8 operation from an idle DUT; entered and left at posedge+1.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        int exp, cyc;
        exp = model(8, int'(av), int'(bv), int'(cv));
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            cyc = k;
            if (done8) break;
        end
        n_checks++;
        if (cyc !== 8 || done8 !== 1'b1) begin
            n_fail++;
            $display("FAIL latency8: got %0d cycles done=%b, want 8 done=1", cyc, done8);
        end
        n_checks++;
        if ({cout8, sum8} !== exp[8:0]) begin
            n_fail++;
            $display("FAIL sum8 %h+%h+%b: got %h, want %h", av, bv, cv, {cout8, sum8}, exp[8:0]);
        end
        n_checks++;
        if (ovf8 !== exp[9]) begin
            n_fail++;
            $display("FAIL ovf8 %h+%h+%b: got %b, want %b", av, bv, cv, ovf8, exp[9]);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width8: got done=%b busy=%b, want 0 0", done8, busy8);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b1; start3 = 1'b1; a8 = 8'h3C; b8 = 8'h05;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0 || busy3 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                         busy8, done8, sum8, cout8, ovf8);
            end
        end
        start8 = 1'b0; start3 = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        op8(8'h3C, 8'h05, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({cout8, ovf8, sum8} !== {1'b0, 1'b0, 8'h41} || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: got sum=%h cout=%b ovf=%b busy=%b, want 41 0 0 0",
                     sum8, cout8, ovf8, busy8);
        end
    endtask

    task automatic test_boundary();
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'h7F, 8'h01, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1);
        op8(8'h80, 8'h80, 1'b0);
        for (int i = 0; i < 16; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic test_back_to_back();
        int e1, e2, cyc;
        e1 = model(8, 8'hA5, 8'h6B, 1);
        e2 = model(8, 8'h12, 8'h34, 0);
        a8 = 8'hA5; b8 = 8'h6B; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            cyc = k;
            if (done8) break;
        end
        n_checks++;
        if (cyc !== 8 || {ovf8, cout8, sum8} !== e1[9:0]) begin
            n_fail++;
            $display("FAIL b2b_first: got cyc=%0d res=%h, want 8 %h", cyc, {ovf8, cout8, sum8},
                     e1[9:0]);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got busy=%b, want 0", busy8);
        end
        @(posedge clk); #1;
        start8 = 1'b0;
        n_checks++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b, want 1", busy8);
        end
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            cyc = k;
            if (done8) break;
        end
        n_checks++;
        if (cyc !== 8 || {ovf8, cout8, sum8} !== e2[9:0]) begin
            n_fail++;
            $display("FAIL b2b_second: got cyc=%0d res=%h, want 8 %h", cyc, {ovf8, cout8, sum8},
                     e2[9:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        a8 = 8'hFF; b8 = 8'h80; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_nodone: got %0d busy/done cycles, want 0", seen);
        end
        op8(8'h10, 8'h20, 1'b0);
        n_checks++;
        if (sum8 !== 8'h30) begin
            n_fail++;
            $display("FAIL reset_restart: got sum=%h, want 30", sum8);
        end
    endtask

    task automatic test_exhaustive3();
        int exp, cyc;
        for (int i = 0; i < 128; i++) begin
            a3 = 3'(i >> 4); b3 = 3'(i >> 1); cin3 = 1'(i);
            exp = model(3, i >> 4, (i >> 1) & 7, i & 1);
            start3 = 1'b1;
            @(posedge clk); #1;
            start3 = 1'b0;
            cyc = 0;
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk); #1;
                cyc = k;
                if (done3) break;
            end
            n_checks++;
            if (cyc !== 3 || {ovf3, cout3, sum3} !== exp[4:0]) begin
                n_fail++;
                $display("FAIL exh3 i=%0d: got cyc=%0d res=%b, want 3 %b", i, cyc,
                         {ovf3, cout3, sum3}, exp[4:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
